logic16_arbiter: RTL
====================

# logic16_arbiter

Two-requester arbiter and sequencer for the shared 16-bit bitwise logic unit (And16/Or16/Xor/Not16 datapath). Each requester presents two 16-bit operands and an operation code over a valid/ready handshake. The block grants the unit round-robin, registers one result per cycle, and returns it on a single response channel tagged with the requester ID. It sits between the CPU-side requesters and the shared logic datapath, so only one operation occupies the unit at a time.

## Interface
Parameters:
- WIDTH, 16, operand/result width; the test plan uses only 16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_a, req0_b  in  16 each  requester 0 operands.
- req0_op  in  2  requester 0 operation: 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored).
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- rsp_valid  out  1  result register holds an undelivered result.
- rsp_ready  in  1  consumer takes the result when high with rsp_valid.
- rsp_id  out  1  requester that issued the held result.
- rsp_out  out  16  held result.

## Operation
- The state is a result-register occupancy flag: EMPTY (rsp_valid=0) or FULL (rsp_valid=1). A `last` pointer records the most recently granted requester.
- Grant (combinational):
  - Only one reqN_valid high: grant that requester.
  - Both high: grant the requester that is not `last`.
  - Neither high: no grant.
- can_accept = EMPTY, or (FULL and rsp_ready).
- reqN_ready = (grant==N) and can_accept. reqN_ready may depend combinationally on reqN_valid and rsp_ready. The two ready outputs are never both high.
- Accept (reqN_valid & reqN_ready) at edge:
  - rsp_out <= op(a,b), computed bitwise per bit i.
  - rsp_id <= N.
  - last <= N.
  - state <= FULL.
- Drain without accept (rsp_valid & rsp_ready, no accept): state <= EMPTY. rsp_out and rsp_id hold their last values.
- Drain and accept in the same cycle: state stays FULL, the new result replaces the old, and there is no bubble.
- FULL with rsp_ready=0: both readys are low. rsp_out, rsp_id and rsp_valid stay stable until the drain.
- A requester whose valid is high stays pending, with operands stable, until its ready is observed. The block does not check this.
- Round-robin guarantee: with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1…. Neither requester waits more than one accept.

## Timing
- Reset (rst_n low, asynchronous, any time):
  - rsp_valid=0, rsp_out=16'h0000, rsp_id=0.
  - last=1, so requester 0 wins the first tie.
  - req0_ready and req1_ready follow the combinational rules from EMPTY.
  - A result in flight is discarded. Deassertion is synchronous to clk by the system reset tree.
- Latency: accept at edge k gives rsp_valid=1 with the result in the cycle after edge k (1 cycle).
- Throughput: one operation per cycle while rsp_ready=1.
- No combinational path from reqN_a, reqN_b or reqN_op to any output. rsp_out is registered only.

## Test plan
- Reset, then req0 AND with a=16'hF0F0, b=16'hFF00 and rsp_ready=1. Required: req0_ready=1 in cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_out=16'hF000.
- All four ops on req1 back-to-back with a=16'h00FF, b=16'h0F0F. Required: OR gives 16'h0FFF, XOR gives 16'h0FF0, NOT gives 16'hFF00, AND gives 16'h000F, on consecutive cycles, each with rsp_id=1.
- Both valid continuously for 6 cycles with rsp_ready=1. Required: rsp_id sequence 0,1,0,1,0,1; the first grant after reset goes to requester 0.
- Backpressure: result FULL and rsp_ready=0 for 3 cycles, req0 valid. Required: req0_ready=0 and rsp_out unchanged for all 3 cycles. When rsp_ready=1, drain and accept happen in the same cycle and rsp_valid stays 1 with the new result.
- Drain only: FULL, no requester valid, rsp_ready=1. Required: rsp_valid=0 next cycle and rsp_out holds its value.
- Reset mid-stream: assert rst_n=0 asynchronously while FULL. Required: rsp_valid=0 and rsp_out=0 immediately, without a clock edge. After release with both requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/logic16_arbiter.sv
// Two-requester round-robin arbiter in front of the shared bitwise logic unit.
// One result register, refilled in the same cycle it drains, so throughput is one op per cycle.
module logic16_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  state_e           state_q, state_d;
  logic             last_q,  last_d;
  logic             id_q,    id_d;
  logic [WIDTH-1:0] out_q,   out_d;

  logic             grant_vld;
  logic             grant_id;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  op_e              sel_op;

  function automatic logic [WIDTH-1:0] apply_op(input op_e op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Grant and handshake. On a tie the requester that did not win last time goes.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    can_accept = (state_q == S_EMPTY) || rsp_ready;
    accept     = grant_vld && can_accept;
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
  end

  // Operand steering only feeds the result register, never an output directly.
  always_comb begin
    sel_a  = grant_id ? req1_a : req0_a;
    sel_b  = grant_id ? req1_b : req0_b;
    sel_op = op_e'(grant_id ? req1_op : req0_op);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    out_d   = out_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) state_d = S_FULL;
      end
      S_FULL: begin
        // A refill in the draining cycle keeps the register full with no bubble.
        if (accept)         state_d = S_FULL;
        else if (rsp_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
    if (accept) begin
      out_d  = apply_op(sel_op, sel_a, sel_b);
      id_d   = grant_id;
      last_d = grant_id;
    end
  end

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      out_q   <= out_d;
    end
  end

  assign rsp_valid = (state_q == S_FULL);
  assign rsp_id    = id_q;
  assign rsp_out   = out_q;

endmodule
